// File: rtl/freq_bcd_convert.sv
// freq_bcd_convert: serial binary-to-packed-BCD converter (double dabble).
// Accepts one unsigned count while idle, runs one shift-add-3 step per cycle,
// and strobes the result for one cycle. Values that do not fit in DIGITS
// decimal digits saturate to all nines and raise out_ovf.
module freq_bcd_convert #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 10
) (
  input  logic                  in_sys_clk,
  input  logic                  in_reset_n,
  input  logic [IN_WIDTH-1:0]   in_count,
  input  logic                  in_valid,
  output logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_valid,
  output logic                  out_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t               state_q;
  logic [IN_WIDTH-1:0]  shift_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;
  logic [BCD_W-1:0]     bcd_out_q;
  logic                 valid_q;
  logic                 ovf_out_q;
  logic                 ready_q;

  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_d;
  logic [IN_WIDTH-1:0]  shift_d;
  logic                 ovf_d;

  // Add 3 to every digit that is 5 or more; 4-bit wrap, no carry between digits.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Saturated result: every digit forced to nine.
  function automatic logic [BCD_W-1:0] saturate_bcd();
    return {DIGITS{4'h9}};
  endfunction

  // One double-dabble step: adjust digits, shift {bcd,shift} left, catch overflow bit.
  always_comb begin
    bcd_adj = add3_digits(bcd_q);
    bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[IN_WIDTH-1]};
    shift_d = shift_q << 1;
    ovf_d   = ovf_q | bcd_adj[BCD_W-1];
  end

  // Control FSM with working registers and registered result outputs.
  always_ff @(posedge in_sys_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_out_q <= '0;
      valid_q   <= 1'b0;
      ovf_out_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            shift_q <= in_count;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_q <= shift_d;
          bcd_q   <= bcd_d;
          ovf_q   <= ovf_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            // Final step: publish the result in the same edge that enters DONE.
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            if (ovf_d) begin
              bcd_out_q <= saturate_bcd();
              ovf_out_q <= 1'b1;
            end else begin
              bcd_out_q <= bcd_d;
              ovf_out_q <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_ready = ready_q;
  assign out_bcd   = bcd_out_q;
  assign out_valid = valid_q;
  assign out_ovf   = ovf_out_q;

endmodule
